// File: rtl/game_ctrl_pkg.sv
// Shared types and constants for the Digger game flow controller.
package game_ctrl_pkg;

    // Screen codes as seen by the screen selector.
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_START       = 3'd1,
        ST_PLAY        = 3'd2,
        ST_WIN         = 3'd3,
        ST_GAME_OVER   = 3'd4,
        ST_LEVEL_INTRO = 3'd5,
        ST_PAUSED      = 3'd6
    } game_state_t;

    // Gold-bag state nibble values that matter for collisions.
    localparam logic [3:0] GOLD_FALLING = 4'd1;
    localparam logic [3:0] GOLD_BROKEN  = 4'd2;

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector: one-cycle pulse when a level input goes 0 -> 1.
module rise_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic r_prev;

    // Remember last cycle's level so a held key yields a single event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_prev <= 1'b0;
        else       r_prev <= in;
    end

    assign pulse = in & ~r_prev;

endmodule

// File: rtl/game_flow_controller.sv
// Game flow controller: collision decode plus screen/level state machine.
//
// state          | meaning
// ---------------+--------------------------------------------
// IDLE           | first cycle after reset
// START          | title screen, waiting for a start key edge
// LEVEL_INTRO    | level banner, held for INTRO_FRAMES frames
// PLAY           | gameplay, collisions live
// PAUSED         | gameplay frozen until the next pause edge
// WIN            | all levels cleared, held for END_FRAMES frames
// GAME_OVER      | lives exhausted, held for END_FRAMES frames
module game_flow_controller
    import game_ctrl_pkg::*;
#(
    parameter int NUM_GOLD     = 4,
    parameter int NUM_LEVELS   = 3,
    parameter int CNT_W        = 11,
    parameter int END_FRAMES   = 1000,
    parameter int INTRO_FRAMES = 90,
    parameter int LVL_W        = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_of_frame,
    input  logic                  start_btn,
    input  logic                  pause_btn,
    input  logic                  terrain_dr,
    input  logic                  empty_square_terrain,
    input  logic                  player_dr,
    input  logic                  shot_dr,
    input  logic                  alien_dr,
    input  logic                  player_awake,
    input  logic [NUM_GOLD-1:0]   gold_dr,
    input  logic [4*NUM_GOLD-1:0] gold_state,
    input  logic                  no_diamond_left,
    input  logic                  no_lives_left,
    output logic                  collision_player_terrain,
    output logic                  collision_fire,
    output logic [NUM_GOLD-1:0]   collision_gold,
    output logic [NUM_GOLD-1:0]   player_eat_gold,
    output logic                  player_died,
    output logic                  alien_died,
    output logic [2:0]            game_state,
    output logic [LVL_W-1:0]      level,
    output logic                  restart_levelN,
    output logic                  reset_scoreN
);

    localparam logic [CNT_W-1:0] INTRO_CNT = CNT_W'(INTRO_FRAMES);
    localparam logic [CNT_W-1:0] END_CNT   = CNT_W'(END_FRAMES);
    localparam logic [LVL_W-1:0] LAST_LVL  = LVL_W'(NUM_LEVELS - 1);

    game_state_t      r_state;
    logic [CNT_W-1:0] r_counter;
    logic [LVL_W-1:0] r_level;
    logic             r_restart_level_n;
    logic             r_reset_score_n;

    logic                w_start_edge;
    logic                w_pause_edge;
    logic                w_play;
    logic [NUM_GOLD-1:0] w_gold_falling_hit;

    rise_edge_detect u_start_edge (
        .clk   (clk),
        .reset (reset),
        .in    (start_btn),
        .pulse (w_start_edge)
    );

    rise_edge_detect u_pause_edge (
        .clk   (clk),
        .reset (reset),
        .in    (pause_btn),
        .pulse (w_pause_edge)
    );

    assign w_play = (r_state == ST_PLAY);

    // Per-bag decode; everything is gated so nothing collides off the play screen.
    for (genvar gi = 0; gi < NUM_GOLD; gi++) begin : g_bag
        logic [3:0] w_bag_state;
        assign w_bag_state            = gold_state[4*gi +: 4];
        assign w_gold_falling_hit[gi] = gold_dr[gi] & (w_bag_state == GOLD_FALLING);
        assign collision_gold[gi]     = w_play & gold_dr[gi] & (player_dr | alien_dr);
        assign player_eat_gold[gi]    = w_play & gold_dr[gi] & player_dr
                                        & (w_bag_state == GOLD_BROKEN);
    end

    assign collision_player_terrain = w_play & terrain_dr & player_dr;
    assign collision_fire           = w_play & shot_dr
                                      & ((terrain_dr & ~empty_square_terrain) | alien_dr);
    assign player_died              = w_play & player_dr & player_awake
                                      & (alien_dr | (|w_gold_falling_hit));
    assign alien_died               = w_play & alien_dr
                                      & (shot_dr | (|w_gold_falling_hit));

    // Screen FSM with frame counter, level register and active-low restart pulses.
    // The counter update is written first; any transition overrides it with a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= ST_IDLE;
            r_counter         <= '0;
            r_level           <= '0;
            r_restart_level_n <= 1'b0;
            r_reset_score_n   <= 1'b0;
        end else begin
            r_restart_level_n <= 1'b1;
            r_reset_score_n   <= 1'b1;

            if (start_of_frame && (r_state != ST_PAUSED) && (r_counter != {CNT_W{1'b1}}))
                r_counter <= r_counter + 1'b1;

            case (r_state)
                ST_IDLE: begin
                    r_state   <= ST_START;
                    r_counter <= '0;
                end
                ST_START: begin
                    if (w_start_edge) begin
                        r_level           <= '0;
                        r_reset_score_n   <= 1'b0;
                        r_restart_level_n <= 1'b0;
                        r_state           <= ST_LEVEL_INTRO;
                        r_counter         <= '0;
                    end
                end
                ST_LEVEL_INTRO: begin
                    if (r_counter >= INTRO_CNT) begin
                        r_state   <= ST_PLAY;
                        r_counter <= '0;
                    end
                end
                ST_PLAY: begin
                    if (no_diamond_left) begin
                        if (r_level == LAST_LVL) begin
                            r_state <= ST_WIN;
                        end else begin
                            r_level           <= r_level + 1'b1;
                            r_restart_level_n <= 1'b0;
                            r_state           <= ST_LEVEL_INTRO;
                        end
                        r_counter <= '0;
                    end else if (no_lives_left) begin
                        r_state   <= ST_GAME_OVER;
                        r_counter <= '0;
                    end else if (w_pause_edge) begin
                        r_state   <= ST_PAUSED;
                        r_counter <= '0;
                    end
                end
                ST_PAUSED: begin
                    if (w_pause_edge) begin
                        r_state   <= ST_PLAY;
                        r_counter <= '0;
                    end
                end
                ST_WIN, ST_GAME_OVER: begin
                    if (r_counter >= END_CNT) begin
                        r_state   <= ST_START;
                        r_counter <= '0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_counter <= '0;
                end
            endcase
        end
    end

    assign game_state     = r_state;
    assign level          = r_level;
    assign restart_levelN = r_restart_level_n;
    assign reset_scoreN   = r_reset_score_n;

endmodule
